// File: rtl/inv_bist.sv
// Built-in self-test sequencer for the inverter datapath: sweeps every input code and checks
// that each response is the complement. Define INV_BIST_LOOP_EN to sweep repeatedly until a mismatch.
module inv_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] stim_o,
  input  logic [WIDTH-1:0] resp_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [WIDTH-1:0] fail_stim,
  output logic [WIDTH-1:0] fail_resp
);

  // state    | meaning
  // ST_IDLE  | waiting for start after reset
  // ST_WAIT  | vector driven, letting the inverter output settle
  // ST_CHECK | compare response against the complement of the vector
  // ST_DONE  | sweep finished or halted on a mismatch, status held
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] STIM_LAST = '1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] stim_nxt, fail_stim_nxt, fail_resp_nxt;
  logic             pass_nxt, fail_nxt;
  logic             loop_pulse, loop_pulse_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      stim_o     <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      fail_stim  <= '0;
      fail_resp  <= '0;
      loop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      stim_o     <= stim_nxt;
      cnt        <= cnt_nxt;
      pass       <= pass_nxt;
      fail       <= fail_nxt;
      fail_stim  <= fail_stim_nxt;
      fail_resp  <= fail_resp_nxt;
      loop_pulse <= loop_pulse_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    stim_nxt       = stim_o;
    cnt_nxt        = cnt;
    pass_nxt       = pass;
    fail_nxt       = fail;
    fail_stim_nxt  = fail_stim;
    fail_resp_nxt  = fail_resp;
    loop_pulse_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stim_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (resp_i != ~stim_o) begin
          fail_stim_nxt = stim_o;
          fail_resp_nxt = resp_i;
          fail_nxt      = 1'b1;
          pass_nxt      = 1'b0;
          state_nxt     = ST_DONE;
        end else if (stim_o == STIM_LAST) begin
          pass_nxt = 1'b1;
`ifdef INV_BIST_LOOP_EN
          // Completed sweep: flag it for one cycle and start over without leaving the busy states.
          loop_pulse_nxt = 1'b1;
          stim_nxt       = '0;
          state_nxt      = ST_WAIT;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          stim_nxt  = stim_o + 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (start) begin
          pass_nxt      = 1'b0;
          fail_nxt      = 1'b0;
          fail_stim_nxt = '0;
          fail_resp_nxt = '0;
          stim_nxt      = '0;
          cnt_nxt       = '0;
          state_nxt     = ST_WAIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_WAIT) || (state == ST_CHECK);
  assign done = (state == ST_DONE) || loop_pulse;

endmodule

// File: tb/tb_inv_bist.sv
// Self-checking bench for inv_bist: emulates the inverter (optionally faulty) and checks every
// cycle of each sweep against a schedule computed from the sweep rules.
module tb_inv_bist;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int S1 = S + 1;
  localparam int NCODES = 1 << W;

  logic         clk, rst, start;
  logic [W-1:0] stim_o, resp_i, fail_stim, fail_resp;
  logic         busy, done, pass, fail;

  int           fault_kind;
  logic [W-1:0] f_mask, f_val, f_code, f_err;

  int vectors = 0;
  int miscompares = 0;

  inv_bist #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .stim_o(stim_o), .resp_i(resp_i),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_stim(fail_stim), .fail_resp(fail_resp)
  );

  // kind 0: good inverter, 1: stuck bits (mask/val), 2: one bad code flipped by err
  function automatic logic [W-1:0] model_resp(input logic [W-1:0] v, input int kind,
                                              input logic [W-1:0] m, input logic [W-1:0] val,
                                              input logic [W-1:0] code, input logic [W-1:0] err);
    logic [W-1:0] r;
    r = ~v;
    case (kind)
      1: r = (r & ~m) | (val & m);
      2: if (v == code) r = r ^ err;
      default: ;
    endcase
    return r;
  endfunction

  assign resp_i = model_resp(stim_o, fault_kind, f_mask, f_val, f_code, f_err);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start, then checks every cycle of the sweep plus a few held DONE cycles.
  task automatic run_sweep(input string name, input int extra_at);
    int fv, last;
    bit found;
    logic [3*W+3:0] got, exp;
    logic [W-1:0] v, exp_stim, exp_fs, exp_fr;
    found = 0;
    fv = 0;
    for (int c = 0; c < NCODES; c++) begin
      v = W'(c);
      if (!found && model_resp(v, fault_kind, f_mask, f_val, f_code, f_err) !== ~v) begin
        found = 1;
        fv = c;
      end
    end
    last = found ? S1 * fv + S1 : S1 * NCODES;
    exp_fs = found ? W'(fv) : '0;
    exp_fr = found ? model_resp(W'(fv), fault_kind, f_mask, f_val, f_code, f_err) : '0;
    @(negedge clk) start = 1'b1;
    for (int n = 0; n <= last + 3; n++) begin
      @(posedge clk);
      #1;
      start = (n == extra_at);
      if (n < last) begin
        exp_stim = W'(n / S1);
        exp = {exp_stim, 1'b1, 1'b0, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}};
      end else begin
        exp_stim = found ? W'(fv) : {W{1'b1}};
        exp = {exp_stim, 1'b0, 1'b1, ~found, found, exp_fs, exp_fr};
      end
      got = {stim_o, busy, done, pass, fail, fail_stim, fail_resp};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: {stim,busy,done,pass,fail,fstim,fresp} got %h expected %h",
                 name, n, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    fault_kind = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({stim_o, busy, done, pass, fail, fail_stim, fail_resp} !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: outputs got %h expected 0",
                 {stim_o, busy, done, pass, fail, fail_stim, fail_resp});
      end
    end
    @(negedge clk) rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({stim_o, busy, done, pass, fail, fail_stim, fail_resp} !== '0) begin
        miscompares++;
        $display("FAIL reset_idle: outputs got %h expected 0",
                 {stim_o, busy, done, pass, fail, fail_stim, fail_resp});
      end
    end
  endtask

  task automatic test_good_sweep();
    fault_kind = 0;
    run_sweep("good_sweep", -1);
  endtask

  task automatic test_stuck_bit();
    fault_kind = 1;
    f_mask = 4'h1;
    f_val = 4'h1;
    run_sweep("stuck_bit0", -1);
    vectors++;
    if ({fail_stim, fail_resp} !== 8'h1F) begin
      miscompares++;
      $display("FAIL stuck_bit0_capture: fail_stim/resp got %h expected 1f", {fail_stim, fail_resp});
    end
  endtask

  task automatic test_restart_ignored_start();
    fault_kind = 0;
    run_sweep("restart_extra_start", 20);
  endtask

  task automatic test_random_faults();
    for (int i = 0; i < 8; i++) begin
      fault_kind = (i % 2) + 1;
      f_mask = W'($urandom_range(1, NCODES - 1));
      f_val  = W'($urandom_range(0, NCODES - 1));
      f_code = W'($urandom_range(0, NCODES - 1));
      f_err  = W'($urandom_range(1, NCODES - 1));
      run_sweep($sformatf("random_fault_%0d", i), -1);
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    fault_kind = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    budget = 0;
    while (stim_o !== 4'h7 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    vectors++;
    if (stim_o !== 4'h7) begin
      miscompares++;
      $display("FAIL reset_mid_reach7: stim_o got %h expected 7 within 100 cycles", stim_o);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({stim_o, busy, done, pass, fail, fail_stim, fail_resp} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: outputs got %h expected 0",
               {stim_o, busy, done, pass, fail, fail_stim, fail_resp});
    end
    @(negedge clk) rst = 1'b0;
    run_sweep("after_reset_mid", -1);
  endtask

`ifdef INV_BIST_LOOP_EN
  task automatic test_loop();
    logic [3*W+3:0] got, exp;
    int fin;
    fin = 3 * S1 * NCODES + S1 * 3 + S1;
    fault_kind = 0;
    @(negedge clk) start = 1'b1;
    for (int n = 0; n <= fin + 2; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n < fin)
        exp = {W'((n % (S1 * NCODES)) / S1), 1'b1,
               (n > 0 && n % (S1 * NCODES) == 0), (n >= S1 * NCODES), 1'b0,
               {W{1'b0}}, {W{1'b0}}};
      else
        exp = {4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'h0};
      got = {stim_o, busy, done, pass, fail, fail_stim, fail_resp};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL loop cycle %0d: {stim,busy,done,pass,fail,fstim,fresp} got %h expected %h",
                 n, got, exp);
      end
      if (n == 3 * S1 * NCODES) begin
        fault_kind = 2;
        f_code = 4'h3;
        f_err = 4'hC;
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fault_kind = 0;
    f_mask = '0;
    f_val = '0;
    f_code = '0;
    f_err = '0;
    test_reset();
`ifdef INV_BIST_LOOP_EN
    test_loop();
`else
    test_good_sweep();
    test_stuck_bit();
    test_restart_ignored_start();
    test_random_faults();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inv_bist.md
Name: inv_bist

Overview:
- On-chip built-in self-test sequencer for the 4-bit inverter datapath.
- Acts as the stimulus/response end of the inverter interface: drives the vector into the inverter's input and samples the inverter's output.
- Sweeps every input code, compares each response against the bitwise complement, and reports pass/fail plus the first failing vector.
- Sits beside the inverter in the top level. Status outputs drive board LEDs.

Parameters:
- WIDTH, 4, vector width in bits; the sweep covers codes 0 .. 2^WIDTH-1.
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling the response; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; sampled in IDLE or DONE only.
- stim_o  output  WIDTH  vector driven to the inverter input.
- resp_i  input  WIDTH  inverter output to check.
- busy  output  1  high while a sweep is running.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when every vector matched.
- fail  output  1  high in DONE when a mismatch stopped the sweep.
- fail_stim  output  WIDTH  stimulus applied at the first mismatch.
- fail_resp  output  WIDTH  response captured at the first mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, stim_o=0, settle counter=0; busy, done, pass and fail all 0; fail_stim=0, fail_resp=0.
- States: IDLE, WAIT, CHECK, DONE. busy=1 in WAIT and CHECK. done=1 in DONE only.
- IDLE:
  - If start=1, set stim_o<=0 and settle counter<=0, then go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Increment the settle counter.
  - When the counter reaches SETTLE_CYCLES-1, clear it and go to CHECK.
  - WAIT therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle): compare resp_i with ~stim_o, full WIDTH, unsigned.
  - Mismatch: fail_stim<=stim_o, fail_resp<=resp_i, fail<=1, pass<=0, go to DONE. The sweep halts on the first failure.
  - Match and stim_o == all ones: pass<=1, go to DONE.
  - Match otherwise: stim_o<=stim_o+1, go to WAIT.
- DONE:
  - Hold all status outputs and stim_o.
  - If start=1, clear pass, fail, fail_stim and fail_resp, set stim_o<=0, and go to WAIT. This is a restart.
- Latency: start is sampled at edge T. A fully passing sweep asserts done at T+1+2^WIDTH*(SETTLE_CYCLES+1). For defaults this is T+49.
- Wrap-around: stim_o never wraps. The all-ones code is the terminal vector.
- start during WAIT or CHECK is ignored. No restart mid-sweep.
- Reset mid-sweep forces IDLE immediately, without waiting for a clock edge. All outputs return to reset values.
- start and rst asserted together: reset wins.
- pass and fail are never both 1.

Optional Feature:
- Macro: INV_BIST_LOOP_EN.
- With INV_BIST_LOOP_EN defined:
  - A fully passing sweep does not enter DONE. It goes from CHECK to WAIT with stim_o<=0.
  - pass is set to 1 and stays 1.
  - done pulses high for exactly one cycle per completed sweep.
  - busy stays 1 throughout.
  - Sweeping continues until a mismatch, which enters DONE as in base mode, or until reset.
- Without the macro: base behaviour, stopping in DONE after one sweep.

Test Plan:
- Reset then idle: hold rst=1 for 3 cycles, then release with start=0 for 10 cycles -> stim_o=0; busy, done, pass and fail all 0 throughout.
- Good inverter: resp_i=~stim_o, pulse start at edge T -> busy=1 from T+1; stim_o steps 0x0..0xF with each value held 3 cycles; done=1, pass=1, fail=0 at T+49.
- Stuck bit: resp_i=~stim_o with bit0 forced to 1, pulse start -> done=1, fail=1, pass=0; fail_stim=0x1, fail_resp=0xF; sweep stopped at vector 0x1.
- Restart and ignored start: after the stuck-bit failure, heal the model and pulse start -> fail cleared; full pass at +49 cycles. An extra start pulse at sweep cycle 20 has no effect.
- Reset mid-sweep: assert rst while stim_o=0x7 -> outputs return to reset values without waiting for a clock edge; the next start sweeps again from 0x0.
- Loop mode (INV_BIST_LOOP_EN defined), good inverter: done pulses exactly one cycle each 48 cycles. Then force resp_i=0 while stim_o=0x3 -> DONE with fail_stim=0x3, fail_resp=0x0.
